instr_fetch_seq: RTL

- Program sequencer upstream of the processor core.
- Holds the PC and reads 16-bit instruction words from a synchronous-read instruction ROM.
- Presents each word on the core's DIN with Run held high, waits for the core's Done, then advances to the next word.
- Stops on a HALT opcode. Counts retired instructions for the bench and debug.

---
 rtl/instr_fetch_seq_pkg.sv | 25 ++
 rtl/instr_fetch_seq_if.sv | 24 ++
 rtl/instr_fetch_seq_pc_counter.sv | 36 +++
 rtl/instr_fetch_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the program sequencer: FSM states, opcodes and
// instruction word field widths.
package proc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_GAP     = 3'd4,
    ST_HALTED  = 3'd5
  } state_e;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int OP_W  = 4;
  localparam int RA_W  = 3;
  localparam int RB_W  = 3;
  localparam int IMM_W = 6;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Bus between the sequencer, the instruction ROM and the core.
// Handshake: DIN is valid while Run is high; the word retires on the rising
// edge where Done is sampled high with Run high. Done with Run low is ignored.
interface instr_fetch_seq_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] MemAddr;
  logic              MemEn;
  logic [DATA_W-1:0] MemData;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;

  modport master (
    output MemAddr, MemEn, DIN, Run,
    input  MemData, Done
  );

  modport slave (
    input  MemAddr, MemEn, DIN, Run,
    output MemData, Done
  );
endinterface

// File: rtl/instr_fetch_seq_pc_counter.sv
// Program counter: synchronous clear, load-zero and increment with natural
// wrap modulo 2^ADDR_W.
module pc_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_zero,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // load_zero wins so a restart never lands on PC 1
  always_comb begin
    pc_d = pc_q;
    if (load_zero) begin
      pc_d = '0;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer: fetches words from a synchronous ROM, issues them to the
// core with Run/Done, stops on HALT. Optional one-word prefetch under
// INSTR_FETCH_PREFETCH_EN.
module instr_fetch_seq
  import proc_pkg::*;
#(
  parameter int         ADDR_W  = 4,
  parameter int         DATA_W  = 16,
  parameter logic [3:0] HALT_OP = OP_HALT
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  instr_fetch_seq_if.master   bus,
  output logic [ADDR_W-1:0]   PC,
  output logic                Halted,
  output logic [15:0]         Retired,
  output state_e              dbg_state
);

  state_e            state_d, state_q;
  logic [DATA_W-1:0] ir_d, ir_q;
  logic [15:0]       retired_d, retired_q;
  logic [15:0]       retired_inc;
  logic              pc_load_zero;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_q;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [DATA_W-1:0] pf_buf_d, pf_buf_q;
  logic              pf_valid_d, pf_valid_q;
  logic              pf_pend_d, pf_pend_q;
  logic              issue_first_d, issue_first_q;
  logic [ADDR_W-1:0] pc_next;

  assign pc_next = pc_q + ADDR_W'(1);
`endif

  pc_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk       (Clock),
    .rst       (Reset),
    .load_zero (pc_load_zero),
    .inc       (pc_inc),
    .pc        (pc_q)
  );

  assign retired_inc = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    retired_d    = retired_q;
    pc_load_zero = 1'b0;
    pc_inc       = 1'b0;
    mem_en       = 1'b0;
    mem_addr     = pc_q;
`ifdef INSTR_FETCH_PREFETCH_EN
    pf_buf_d     = pf_buf_q;
    pf_valid_d   = pf_valid_q;
    pf_pend_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          pc_load_zero = 1'b1;
          retired_d    = '0;
          state_d      = ST_FETCH;
`ifdef INSTR_FETCH_PREFETCH_EN
          pf_valid_d   = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        mem_en  = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        ir_d = bus.MemData;
        if (bus.MemData[DATA_W-1 -: OP_W] == HALT_OP) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef INSTR_FETCH_PREFETCH_EN
        // read PC+1 on the first issue cycle; the word lands one cycle later
        if (issue_first_q) begin
          mem_en   = 1'b1;
          mem_addr = pc_next;
        end
        pf_pend_d = issue_first_q;
        if (pf_pend_q) begin
          pf_buf_d   = bus.MemData;
          pf_valid_d = 1'b1;
        end
`endif
        if (bus.Done) begin
          pc_inc    = 1'b1;
          retired_d = retired_inc;
`ifdef INSTR_FETCH_PREFETCH_EN
          state_d   = (pf_valid_q || pf_pend_q) ? ST_GAP : ST_FETCH;
`else
          state_d   = ST_FETCH;
`endif
        end
      end
`ifdef INSTR_FETCH_PREFETCH_EN
      ST_GAP: begin
        pf_valid_d = 1'b0;
        if (pf_buf_q[DATA_W-1 -: OP_W] == HALT_OP) begin
          state_d = ST_HALTED;
        end else begin
          ir_d    = pf_buf_q;
          state_d = ST_ISSUE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef INSTR_FETCH_PREFETCH_EN
    issue_first_d = (state_d == ST_ISSUE) && (state_q != ST_ISSUE);
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

`ifdef INSTR_FETCH_PREFETCH_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pf_buf_q      <= '0;
      pf_valid_q    <= 1'b0;
      pf_pend_q     <= 1'b0;
      issue_first_q <= 1'b0;
    end else begin
      pf_buf_q      <= pf_buf_d;
      pf_valid_q    <= pf_valid_d;
      pf_pend_q     <= pf_pend_d;
      issue_first_q <= issue_first_d;
    end
  end
`endif

  assign bus.MemEn   = mem_en;
  assign bus.MemAddr = mem_addr;
  assign bus.DIN     = ir_q;
  assign bus.Run     = (state_q == ST_ISSUE);
  assign Halted      = (state_q == ST_HALTED);
  assign PC          = pc_q;
  assign Retired     = retired_q;
  assign dbg_state   = state_q;

endmodule
